// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and command-entry layout for the ALU command sequencer.
// With ALU_SEQ_CHAIN_EN defined each entry also carries the chain bit.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_MAX = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

`ifdef ALU_SEQ_CHAIN_EN
    typedef struct packed {
        logic       chain;
        logic [2:0] op;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_entry_t;
`else
    typedef struct packed {
        logic [2:0] op;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_entry_t;
`endif

    localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a command source (master) and the sequencer (slave).
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       cmd_chain;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two (pointers wrap naturally).
// No read bypass: rdata is always the stored head entry.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives the ALU from registers and returns captured results.
// Define ALU_SEQ_CHAIN_EN to let a command take operand A from the previous result.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_cmd_sequencer_if.slave        sif,
    output logic [3:0]                AluA,
    output logic [3:0]                AluB,
    output logic [2:0]                AluOp,
    input  logic [3:0]                AluResult,
    input  logic                      AluZero,
    output logic                      busy
);
    seq_state_t       state;
    seq_state_t       next_state;
    cmd_entry_t       wr_entry;
    cmd_entry_t       rd_entry;
    logic [ENTRY_W-1:0] rd_bits;
    logic             push;
    logic             pop;
    logic             capture;
    logic             full;
    logic             empty;
    logic [3:0]       next_a;
    logic [3:0]       rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_err_q;

    assign sif.cmd_ready = !full;
    assign push          = sif.cmd_valid && !full;

    always_comb begin
        wr_entry    = '0;
        wr_entry.a  = sif.cmd_a;
        wr_entry.b  = sif.cmd_b;
        wr_entry.op = sif.cmd_op;
`ifdef ALU_SEQ_CHAIN_EN
        wr_entry.chain = sif.cmd_chain;
`endif
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_bits),
        .full  (full),
        .empty (empty)
    );

    assign rd_entry = cmd_entry_t'(rd_bits);

`ifdef ALU_SEQ_CHAIN_EN
    assign next_a = rd_entry.chain ? rsp_result_q : rd_entry.a;
`else
    logic unused_chain;
    assign unused_chain = sif.cmd_chain;
    assign next_a = rd_entry.a;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pops happen only from IDLE or on the RESP handshake, so Alu* stay stable otherwise.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                capture    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                if (sif.rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = DRIVE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AluA  <= '0;
            AluB  <= '0;
            AluOp <= '0;
        end else if (pop) begin
            AluA  <= next_a;
            AluB  <= rd_entry.b;
            AluOp <= rd_entry.op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else if (capture) begin
            rsp_result_q <= AluResult;
            rsp_zero_q   <= AluZero;
            rsp_err_q    <= (AluOp > OP_MAX);
        end
    end

    assign sif.rsp_valid  = (state == RESP);
    assign sif.rsp_result = rsp_result_q;
    assign sif.rsp_zero   = rsp_zero_q;
    assign sif.rsp_err    = rsp_err_q;
    assign busy           = !empty || (state != IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
// Expectations for chained commands follow ALU_SEQ_CHAIN_EN.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       busy;
    int         checks;
    int         failures;

    alu_cmd_sequencer_if sif ();

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sif       (sif),
        .AluA      (alu_a),
        .AluB      (alu_b),
        .AluOp     (alu_op),
        .AluResult (alu_result),
        .AluZero   (alu_zero),
        .busy      (busy)
    );

    // Reference ALU: illegal opcodes yield 0.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NOT:  alu_result = ~alu_a;
            default: alu_result = 4'h0;
        endcase
        alu_zero = (alu_result == 4'h0);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op, input logic chain);
        sif.cmd_valid = valid;
        sif.cmd_a     = a;
        sif.cmd_b     = b;
        sif.cmd_op    = op;
        sif.cmd_chain = chain;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Push one command into an idle sequencer and check its response.
    task automatic runCmd(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic chain,
                          input logic [3:0] exp_result, input logic exp_zero, input logic exp_err);
        int wait_cycles;
        sif.rsp_ready = 1'b1;
        applyStimulus(1'b1, a, b, op, chain);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 3'h0, 1'b0);
        wait_cycles = 0;
        while (sif.rsp_valid !== 1'b1 && wait_cycles < 10) begin
            tick();
            wait_cycles++;
        end
        checkOutput({tag, "_valid"}, 8'(sif.rsp_valid), 8'h1);
        checkOutput({tag, "_result"}, 8'(sif.rsp_result), 8'(exp_result));
        checkOutput({tag, "_zero"}, 8'(sif.rsp_zero), 8'(exp_zero));
        checkOutput({tag, "_err"}, 8'(sif.rsp_err), 8'(exp_err));
        tick();
    endtask

    initial begin
        int stale;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        sif.rsp_ready = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'h0, 3'h0, 1'b0);
        #1 rst = 1'b1;
        tick();
        tick();

        $display("[TB] reset values");
        checkOutput("rst_cmd_ready", 8'(sif.cmd_ready), 8'h1);
        checkOutput("rst_rsp_valid", 8'(sif.rsp_valid), 8'h0);
        checkOutput("rst_busy", 8'(busy), 8'h0);
        checkOutput("rst_alu_a", 8'(alu_a), 8'h0);
        checkOutput("rst_alu_b", 8'(alu_b), 8'h0);
        checkOutput("rst_alu_op", 8'(alu_op), 8'h0);
        checkOutput("rst_rsp_result", 8'(sif.rsp_result), 8'h0);
        checkOutput("rst_rsp_zero", 8'(sif.rsp_zero), 8'h0);
        checkOutput("rst_rsp_err", 8'(sif.rsp_err), 8'h0);
        rst = 1'b0;
        tick();

        $display("[TB] latency 3+5");
        sif.rsp_ready = 1'b1;
        applyStimulus(1'b1, 4'd3, 4'd5, OP_ADD, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 4'h0, 3'h0, 1'b0);
        checkOutput("lat_n1_alu_a", 8'(alu_a), 8'h0);
        checkOutput("lat_n1_valid", 8'(sif.rsp_valid), 8'h0);
        checkOutput("lat_n1_busy", 8'(busy), 8'h1);
        tick();
        checkOutput("lat_n2_alu_a", 8'(alu_a), 8'h3);
        checkOutput("lat_n2_alu_b", 8'(alu_b), 8'h5);
        checkOutput("lat_n2_alu_op", 8'(alu_op), 8'(OP_ADD));
        checkOutput("lat_n2_valid", 8'(sif.rsp_valid), 8'h0);
        tick();
        checkOutput("lat_n3_valid", 8'(sif.rsp_valid), 8'h1);
        checkOutput("lat_n3_result", 8'(sif.rsp_result), 8'h8);
        checkOutput("lat_n3_zero", 8'(sif.rsp_zero), 8'h0);
        checkOutput("lat_n3_err", 8'(sif.rsp_err), 8'h0);
        tick();
        checkOutput("lat_n4_valid", 8'(sif.rsp_valid), 8'h0);
        checkOutput("lat_n4_busy", 8'(busy), 8'h0);
        tick();
        tick();
        checkOutput("hold_alu_a", 8'(alu_a), 8'h3);
        checkOutput("hold_alu_b", 8'(alu_b), 8'h5);

        $display("[TB] arithmetic and logic vectors");
        runCmd("sub_4_4", 4'd4, 4'd4, OP_SUB, 1'b0, 4'h0, 1'b1, 1'b0);
        runCmd("sub_2_3", 4'd2, 4'd3, OP_SUB, 1'b0, 4'hF, 1'b0, 1'b0);
        runCmd("add_15_1", 4'd15, 4'd1, OP_ADD, 1'b0, 4'h0, 1'b1, 1'b0);
        runCmd("and_c_a", 4'hC, 4'hA, OP_AND, 1'b0, 4'h8, 1'b0, 1'b0);
        runCmd("or_c_3", 4'hC, 4'h3, OP_OR, 1'b0, 4'hF, 1'b0, 1'b0);
        runCmd("not_5", 4'h5, 4'h0, OP_NOT, 1'b0, 4'hA, 1'b0, 1'b0);

        $display("[TB] illegal opcode");
        runCmd("illegal_110", 4'd9, 4'd6, 3'b110, 1'b0, 4'h0, 1'b1, 1'b1);
        checkOutput("illegal_issued_op", 8'(alu_op), 8'h6);
        runCmd("legal_after", 4'd1, 4'd1, OP_OR, 1'b0, 4'h1, 1'b0, 1'b0);

        $display("[TB] backpressure capacity");
        sif.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 4'd2, OP_ADD, 1'b0);
            checkOutput($sformatf("bp_ready%0d", i), 8'(sif.cmd_ready), 8'(i < 5));
            tick();
        end
        checkOutput("bp_ready_after", 8'(sif.cmd_ready), 8'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 3'h0, 1'b0);
        checkOutput("bp_busy", 8'(busy), 8'h1);
        sif.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_rsp%0d_valid", k), 8'(sif.rsp_valid), 8'h1);
            checkOutput($sformatf("bp_rsp%0d_result", k), 8'(sif.rsp_result), 8'(k + 3));
            tick();
            checkOutput($sformatf("bp_gap%0d_valid", k), 8'(sif.rsp_valid), 8'h0);
            if (k == 0) begin
                checkOutput("bp_ready_reopen", 8'(sif.cmd_ready), 8'h1);
            end
            if (k < 4) begin
                tick();
            end
        end
        checkOutput("bp_drained_busy", 8'(busy), 8'h0);

        $display("[TB] reset mid-operation");
        sif.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd7, 4'd1, OP_ADD, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'h0, 4'h0, 3'h0, 1'b0);
        checkOutput("mid_pre_valid", 8'(sif.rsp_valid), 8'h1);
        checkOutput("mid_pre_busy", 8'(busy), 8'h1);
        checkOutput("mid_pre_ready", 8'(sif.cmd_ready), 8'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 8'(sif.rsp_valid), 8'h0);
        checkOutput("mid_rst_busy", 8'(busy), 8'h0);
        checkOutput("mid_rst_ready", 8'(sif.cmd_ready), 8'h1);
        checkOutput("mid_rst_alu_a", 8'(alu_a), 8'h0);
        tick();
        rst = 1'b0;
        sif.rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sif.rsp_valid === 1'b1) begin
                stale++;
            end
        end
        checkOutput("mid_stale_rsps", 8'(stale), 8'h0);
        checkOutput("mid_post_busy", 8'(busy), 8'h0);

        $display("[TB] chain behaviour");
`ifdef ALU_SEQ_CHAIN_EN
        runCmd("chain_first", 4'd5, 4'd4, OP_ADD, 1'b1, 4'h4, 1'b0, 1'b0);
        runCmd("chain_base", 4'd1, 4'd2, OP_ADD, 1'b0, 4'h3, 1'b0, 1'b0);
        runCmd("chain_next", 4'd9, 4'd4, OP_ADD, 1'b1, 4'h7, 1'b0, 1'b0);
`else
        runCmd("chain_first", 4'd5, 4'd4, OP_ADD, 1'b1, 4'h9, 1'b0, 1'b0);
        runCmd("chain_base", 4'd1, 4'd2, OP_ADD, 1'b0, 4'h3, 1'b0, 1'b0);
        runCmd("chain_next", 4'd9, 4'd4, OP_ADD, 1'b1, 4'hD, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
